bcd_timer: RTL and testbench

Three-digit BCD minute/second timer that consumes the keypad encoder's outputs (`D`, `loadn`, `pgt_1Hz`) and the shared `enablen` mode line. While programming (`enablen`=1), each debounced key strobe shifts the key's digit into the display register. While cooking (`enablen`=0), each 1 Hz strobe decrements the time with BCD borrow down to 0:00. It sits between the encoder and the display/control logic and reports when the countdown expires.

---
 rtl/bcd_timer.sv | 113 +++++++++++
 tb/tb_bcd_timer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_timer.sv
// Three-digit BCD minute/second timer: shifts keyed digits in while programming
// and counts down with BCD borrow on each 1 Hz strobe edge while cooking.
module bcd_timer #(
    parameter int unsigned SEC_TENS_MAX = 5
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [3:0] D,
    input  logic       loadn,
    input  logic       pgt_1Hz,
    input  logic       enablen,
    input  logic       clr_time,
    output logic [3:0] mins,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       zero,
    output logic       done
);

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(9);
    localparam logic [DIGIT_W-1:0] TENS_MAX  = DIGIT_W'(SEC_TENS_MAX);
    localparam logic [DIGIT_W-1:0] DIGIT_ONE = DIGIT_W'(1);
    localparam logic [DIGIT_W-1:0] DIGIT_ZERO = '0;

    logic               s1_pgt;
    logic               s2_pgt;
    logic               s1_loadn;
    logic               s1_enablen;
    logic [DIGIT_W-1:0] s1_d;
    logic               strobe_evt_c;

    logic [DIGIT_W-1:0] mins_nxt;
    logic [DIGIT_W-1:0] tens_nxt;
    logic [DIGIT_W-1:0] ones_nxt;
    logic               zero_nxt;
    logic               done_nxt;

    // Input stage: strobe and its qualifiers sampled together so they stay aligned
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            s1_pgt     <= 1'b0;
            s2_pgt     <= 1'b0;
            s1_loadn   <= 1'b0;
            s1_enablen <= 1'b0;
            s1_d       <= '0;
        end else begin
            s1_pgt     <= pgt_1Hz;
            s2_pgt     <= s1_pgt;
            s1_loadn   <= loadn;
            s1_enablen <= enablen;
            s1_d       <= D;
        end
    end

    assign strobe_evt_c = s1_pgt & ~s2_pgt;

    // Next-digit logic; clr_time outranks a coincident strobe event
    always_comb begin
        mins_nxt = mins;
        tens_nxt = sec_tens;
        ones_nxt = sec_ones;
        done_nxt = 1'b0;

        if (clr_time) begin
            mins_nxt = DIGIT_ZERO;
            tens_nxt = DIGIT_ZERO;
            ones_nxt = DIGIT_ZERO;
        end else if (strobe_evt_c) begin
            if (s1_enablen) begin
                if (!s1_loadn && (s1_d <= DIGIT_MAX)) begin
                    mins_nxt = sec_tens;
                    tens_nxt = sec_ones;
                    ones_nxt = s1_d;
                end
            end else if (!zero) begin
                if (sec_ones != DIGIT_ZERO) begin
                    ones_nxt = sec_ones - DIGIT_ONE;
                end else if (sec_tens != DIGIT_ZERO) begin
                    ones_nxt = DIGIT_MAX;
                    tens_nxt = sec_tens - DIGIT_ONE;
                end else begin
                    ones_nxt = DIGIT_MAX;
                    tens_nxt = TENS_MAX;
                    mins_nxt = mins - DIGIT_ONE;
                end
                done_nxt = (mins_nxt == DIGIT_ZERO) && (tens_nxt == DIGIT_ZERO)
                           && (ones_nxt == DIGIT_ZERO);
            end
        end
    end

    assign zero_nxt = (mins_nxt == DIGIT_ZERO) && (tens_nxt == DIGIT_ZERO)
                      && (ones_nxt == DIGIT_ZERO);

    // Digit, zero-flag and done registers
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            mins     <= '0;
            sec_tens <= '0;
            sec_ones <= '0;
            zero     <= 1'b1;
            done     <= 1'b0;
        end else begin
            mins     <= mins_nxt;
            sec_tens <= tens_nxt;
            sec_ones <= ones_nxt;
            zero     <= zero_nxt;
            done     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_timer.sv
// Randomized and directed bench for bcd_timer against a minutes/seconds arithmetic model.
module tb_bcd_timer;

    localparam int TENS_MAX = 5;

    logic       clk = 1'b0;
    logic       clear;
    logic [3:0] D;
    logic       loadn;
    logic       pgt_1Hz;
    logic       enablen;
    logic       clr_time;
    logic [3:0] mins;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       zero;
    logic       done;

    always #5 clk = ~clk;

    bcd_timer #(.SEC_TENS_MAX(TENS_MAX)) dut (
        .clk(clk), .clear(clear), .D(D), .loadn(loadn), .pgt_1Hz(pgt_1Hz),
        .enablen(enablen), .clr_time(clr_time), .mins(mins), .sec_tens(sec_tens),
        .sec_ones(sec_ones), .zero(zero), .done(done)
    );

    int   total = 0;
    int   bad   = 0;
    // Model: minutes digit and a two-digit seconds value (0..99, tens may exceed 5)
    int   mm = 0;
    int   ss = 0;
    logic exp_done = 1'b0;

    wire [13:0] obs = {mins, sec_tens, sec_ones, zero, done};

    function automatic logic [13:0] exp_vec();
        return {4'(mm), 4'(ss / 10), 4'(ss % 10), (mm == 0 && ss == 0), exp_done};
    endfunction

    // Drive one strobe (rise, one cycle high) and advance the model; returns at
    // the negedge after the update edge.
    task automatic strobe(input logic [3:0] d, input logic ln);
        @(negedge clk);
        D = d; loadn = ln; pgt_1Hz = 1'b1;
        @(negedge clk);
        pgt_1Hz = 1'b0;
        @(negedge clk);
        exp_done = 1'b0;
        if (enablen) begin
            if (!ln && d <= 4'd9) begin
                mm = ss / 10;
                ss = (ss % 10) * 10 + int'(d);
            end
        end else if (mm != 0 || ss != 0) begin
            if (ss > 0) ss = ss - 1;
            else begin
                mm = mm - 1;
                ss = TENS_MAX * 10 + 9;
            end
            exp_done = (mm == 0 && ss == 0);
        end
    endtask

    task automatic load3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        enablen = 1'b1;
        strobe(a, 1'b0);
        strobe(b, 1'b0);
        strobe(c, 1'b0);
    endtask

    task automatic test_reset();
        clear = 1'b1; D = '0; loadn = 1'b1; pgt_1Hz = 1'b0; enablen = 1'b1; clr_time = 1'b0;
        repeat (3) @(negedge clk);
        mm = 0; ss = 0; exp_done = 1'b0;
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL reset: got %h want %h", obs, exp_vec()); end
        clear = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL reset_release: got %h want %h", obs, exp_vec()); end
    endtask

    task automatic test_load();
        logic [3:0] keys [3];
        keys = '{4'd1, 4'd3, 4'd0};
        enablen = 1'b1;
        for (int i = 0; i < 3; i++) begin
            strobe(keys[i], 1'b0);
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL load_key%0d: got %h want %h", i, obs, exp_vec()); end
        end
        total++;
        if (obs !== 14'h0c_c0 >> 0 && obs !== {12'h130, 2'b00}) begin
            bad++; $display("FAIL load_130: got %h want %h", obs, {12'h130, 2'b00});
        end
    endtask

    task automatic test_invalid_shift();
        strobe(4'd12, 1'b0);
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL invalid_key: got %h want %h", obs, exp_vec()); end
        strobe(4'd4, 1'b0);
        total++;
        if (obs !== {12'h304, 2'b00}) begin bad++; $display("FAIL shift_out: got %h want %h", obs, {12'h304, 2'b00}); end
        strobe(4'd7, 1'b1);
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL loadn_high: got %h want %h", obs, exp_vec()); end
    endtask

    task automatic test_borrow();
        load3(4'd1, 4'd0, 4'd0);
        enablen = 1'b0;
        strobe(4'd0, 1'b0);
        total++;
        if (obs !== {12'h059, 2'b00}) begin bad++; $display("FAIL borrow_min: got %h want %h", obs, {12'h059, 2'b00}); end
        load3(4'd2, 4'd7, 4'd5);
        enablen = 1'b0;
        for (int i = 0; i < 76; i++) begin
            strobe(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL borrow_tick%0d: got %h want %h", i, obs, exp_vec()); end
        end
        total++;
        if (obs !== {12'h159, 2'b00}) begin bad++; $display("FAIL borrow_275: got %h want %h", obs, {12'h159, 2'b00}); end
    endtask

    task automatic test_expiry();
        load3(4'd0, 4'd0, 4'd2);
        enablen = 1'b0;
        strobe(4'd0, 1'b0);
        total++;
        if (obs !== {12'h001, 2'b00}) begin bad++; $display("FAIL expiry_001: got %h want %h", obs, {12'h001, 2'b00}); end
        strobe(4'd0, 1'b0);
        total++;
        if (obs !== {12'h000, 2'b11}) begin bad++; $display("FAIL expiry_done: got %h want %h", obs, {12'h000, 2'b11}); end
        @(negedge clk);
        exp_done = 1'b0;
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL done_width: got %h want %h", obs, exp_vec()); end
        for (int i = 0; i < 3; i++) begin
            strobe(4'd0, 1'b0);
            total++;
            if (obs !== {12'h000, 2'b10}) begin bad++; $display("FAIL hold_zero%0d: got %h want %h", i, obs, {12'h000, 2'b10}); end
        end
    endtask

    task automatic test_latency();
        load3(4'd0, 4'd0, 4'd5);
        enablen = 1'b0;
        @(negedge clk);
        pgt_1Hz = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL latency_early: got %h want %h", obs, exp_vec()); end
        @(negedge clk);
        ss = ss - 1;
        total++;
        if (obs !== {12'h004, 2'b00}) begin bad++; $display("FAIL latency_update: got %h want %h", obs, {12'h004, 2'b00}); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL held_strobe%0d: got %h want %h", i, obs, exp_vec()); end
        end
        pgt_1Hz = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL strobe_release: got %h want %h", obs, exp_vec()); end
    endtask

    task automatic test_priority();
        load3(4'd5, 4'd0, 4'd0);
        enablen = 1'b0;
        @(negedge clk);
        pgt_1Hz = 1'b1;
        @(negedge clk);
        pgt_1Hz = 1'b0;
        clr_time = 1'b1;
        @(negedge clk);
        clr_time = 1'b0;
        mm = 0; ss = 0; exp_done = 1'b0;
        total++;
        if (obs !== {12'h000, 2'b10}) begin bad++; $display("FAIL clr_time_wins: got %h want %h", obs, {12'h000, 2'b10}); end
        @(negedge clk);
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL clr_time_after: got %h want %h", obs, exp_vec()); end

        load3(4'd3, 4'd2, 4'd1);
        enablen = 1'b0;
        strobe(4'd0, 1'b0);
        total++;
        if (obs !== {12'h320, 2'b00}) begin bad++; $display("FAIL pre_clear: got %h want %h", obs, {12'h320, 2'b00}); end
        @(posedge clk);
        #2 clear = 1'b1;
        #1;
        mm = 0; ss = 0; exp_done = 1'b0;
        total++;
        if (obs !== {12'h000, 2'b10}) begin bad++; $display("FAIL async_clear: got %h want %h", obs, {12'h000, 2'b10}); end
        @(negedge clk);
        clear = 1'b0;
        strobe(4'd0, 1'b0);
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL clear_then_strobe: got %h want %h", obs, exp_vec()); end
    endtask

    task automatic test_random();
        int op;
        for (int i = 0; i < 200; i++) begin
            op = int'($urandom_range(0, 9));
            if (op == 0) begin
                @(negedge clk);
                clr_time = 1'b1;
                @(negedge clk);
                clr_time = 1'b0;
                mm = 0; ss = 0; exp_done = 1'b0;
            end else if (op == 1) begin
                enablen = ~enablen;
                @(negedge clk);
                exp_done = 1'b0;
            end else begin
                strobe(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
            end
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL random_op%0d: got %h want %h", i, obs, exp_vec()); end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_invalid_shift();
        test_borrow();
        test_expiry();
        test_latency();
        test_priority();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
